// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signal bundle for icache_responder.
// The cache uses the slave modport; the fetch stage and the memory sit on master.
interface icache_responder_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] instr;
  logic        stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] miss_count;

  modport slave (
    input  fetch_req, fetch_addr, mem_data, mem_data_valid,
    output instr, stall, mem_rd, mem_addr, miss_count
  );

  modport master (
    output fetch_req, fetch_addr, mem_data, mem_data_valid,
    input  instr, stall, mem_rd, mem_addr, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: combinational hits, 8-word block refill.
// Define ICACHE_STATS_EN to build the saturating miss counter; otherwise miss_count is 0.
module icache_responder #(
  parameter int MEM_WORDS = 8,
  parameter int NUM_SETS  = 32
) (
  input  logic clk,
  input  logic rst,
  icache_responder_if.slave bus
);
  localparam int OFF_W = $clog2(MEM_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 15 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(MEM_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [OFF_W-1:0] issue_cnt;
  logic [OFF_W-1:0] rx_cnt;
  logic [NUM_SETS-1:0] valid;

  logic [TAG_W-1:0] tag_mem  [NUM_SETS];
  logic [15:0]      data_mem [NUM_SETS*MEM_WORDS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_byte_bit;

  assign req_off         = bus.fetch_addr[OFF_W:1];
  assign req_idx         = bus.fetch_addr[OFF_W+IDX_W:OFF_W+1];
  assign req_tag         = bus.fetch_addr[15:OFF_W+IDX_W+1];
  assign unused_byte_bit = bus.fetch_addr[0];

  logic             lookup, hit, miss, fill_we, last_rx;
  logic [OFF_W-1:0] next_issue;

  assign lookup     = bus.fetch_req && (state == IDLE);
  assign hit        = lookup && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign miss       = lookup && !hit;
  assign fill_we    = (state == FILL) && bus.mem_data_valid;
  assign last_rx    = fill_we && (rx_cnt == LAST);
  assign next_issue = issue_cnt + OFF_W'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bus.stall = 1'b0;
    bus.instr = '0;
    if (state == FILL || miss) bus.stall = 1'b1;
    if (hit)                   bus.instr = data_mem[{req_idx, req_off}];
  end

  // Read issue and return counting run independently: returns are counted, never timed.
  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fill_tag     <= '0;
      fill_idx     <= '0;
      issue_cnt    <= '0;
      rx_cnt       <= '0;
      valid        <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state          <= FILL;
            fill_tag       <= req_tag;
            fill_idx       <= req_idx;
            valid[req_idx] <= 1'b0;
            issue_cnt      <= '0;
            rx_cnt         <= '0;
            bus.mem_rd     <= 1'b1;
            bus.mem_addr   <= {req_tag, req_idx, {OFF_W{1'b0}}, 1'b0};
          end
        end
        FILL: begin
          if (bus.mem_rd) begin
            if (issue_cnt == LAST) begin
              bus.mem_rd <= 1'b0;
            end else begin
              issue_cnt    <= next_issue;
              bus.mem_addr <= {fill_tag, fill_idx, next_issue, 1'b0};
            end
          end
          if (fill_we) begin
            rx_cnt <= rx_cnt + OFF_W'(1);
            if (last_rx) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the arrays carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[{fill_idx, rx_cnt}] <= bus.mem_data;
    if (last_rx) tag_mem[fill_idx]            <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            miss_cnt <= '0;
    else if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
  end

  assign bus.miss_count = miss_cnt;
`else
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: table vectors, hand-written corner
// sequences and randomized fetches against a set/tag reference model.
module tb_icache_responder;
  logic clk;
  logic rst;
  int   cyc;
  int   lat;
  int   tests;
  int   fails;
  int   misses_model;

  icache_responder_if bus ();

  icache_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Reference model: per-set valid and tag, derived from the address split alone.
  bit       mvalid [32];
  bit [6:0] mtag   [32];

  typedef struct {
    logic        req;
    logic [15:0] addr;
    bit          miss;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  rd_t pend[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a read seen in cycle c returns in cycle c+lat; the word at A holds A.
  initial begin
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = '0;
    forever begin
      @(negedge clk);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rd_t r;
        r = pend.pop_front();
        bus.mem_data_valid = 1'b1;
        bus.mem_data       = r.addr;
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = 16'hDEAD;
      end
      if (bus.mem_rd) pend.push_back('{addr: bus.mem_addr, due: cyc + lat});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_mc();
    return STATS ? 16'(misses_model) : 16'h0000;
  endfunction

  function automatic bit model_miss(input logic [15:0] a);
    return !(mvalid[a[8:4]] && mtag[a[8:4]] == a[15:9]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    misses_model = 0;
  endtask

  task automatic model_fill(input logic [15:0] a);
    mvalid[a[8:4]] = 1'b1;
    mtag[a[8:4]]   = a[15:9];
    misses_model++;
  endtask

  // Request one address and follow it until served; checks stall length,
  // the read burst (count, timing, addresses) and the returned word.
  task automatic do_fetch(input logic [15:0] a, input bit exp_miss, input string name);
    int stall_cycles;
    int rd_cycles;
    bit rd_ok;
    stall_cycles = 0;
    rd_cycles    = 0;
    rd_ok        = 1'b1;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (bus.mem_rd) begin
        if (c != rd_cycles + 1 || bus.mem_addr != {a[15:4], rd_cycles[2:0], 1'b0}) rd_ok = 1'b0;
        rd_cycles++;
      end
      if (!bus.stall) break;
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    check({name, " stall cycles"}, stall_cycles, exp_miss ? 9 + lat : 0);
    check({name, " read count"}, rd_cycles, exp_miss ? 8 : 0);
    check({name, " read addresses"}, {31'b0, rd_ok}, 32'd1);
    check({name, " instr"}, {16'b0, bus.instr}, {16'b0, a[15:1], 1'b0});
    if (exp_miss) model_fill(a);
  endtask

  task automatic idle_cycles(input logic [15:0] a, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = a;
      #1;
      check({name, " stall"}, {31'b0, bus.stall}, 32'd0);
      check({name, " mem_rd"}, {31'b0, bus.mem_rd}, 32'd0);
      check({name, " instr"}, {16'b0, bus.instr}, 32'd0);
      check({name, " miss_count"}, {16'b0, bus.miss_count}, {16'b0, exp_mc()});
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  vec_t vecs[13];

  initial begin
    tests = 0;
    fails = 0;
    lat   = 4;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset instr", {16'b0, bus.instr}, 32'd0);
    check("reset stall", {31'b0, bus.stall}, 32'd0);
    check("reset mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("reset mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    check("reset miss_count", {16'b0, bus.miss_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    vecs[0]  = '{1'b1, 16'h0006, 1'b1};
    vecs[1]  = '{1'b1, 16'h000A, 1'b0};
    vecs[2]  = '{1'b1, 16'h000E, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 16'hBEEF, 1'b0};
    vecs[5]  = '{1'b1, 16'h0206, 1'b1};
    vecs[6]  = '{1'b1, 16'h0200, 1'b0};
    vecs[7]  = '{1'b1, 16'h0006, 1'b1};
    vecs[8]  = '{1'b1, 16'h0010, 1'b1};
    vecs[9]  = '{1'b1, 16'h001F, 1'b0};
    vecs[10] = '{1'b1, 16'h0007, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFE, 1'b1};
    vecs[12] = '{1'b1, 16'hFFF0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].req) do_fetch(vecs[i].addr, vecs[i].miss, $sformatf("vec%0d", i));
      else             idle_cycles(vecs[i].addr, 4, $sformatf("vec%0d idle", i));
    end
    @(negedge clk);
    #1;
    check("table miss_count", {16'b0, bus.miss_count}, {16'b0, exp_mc()});

    // Last return and a new address in the same cycle: the new one is looked up a cycle later.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0030;
    repeat (12) @(negedge clk);
    bus.fetch_addr = 16'h0046;
    #1;
    check("overlap last-return stall", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    #1;
    check("overlap next-cycle stall", {31'b0, bus.stall}, 32'd1);
    check("overlap next-cycle mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    @(negedge clk);
    #1;
    check("overlap second burst mem_rd", {31'b0, bus.mem_rd}, 32'd1);
    check("overlap second burst mem_addr", {16'b0, bus.mem_addr}, 32'h0040);
    for (int i = 0; i < 40 && bus.stall; i++) begin
      @(negedge clk);
      #1;
    end
    check("overlap served stall", {31'b0, bus.stall}, 32'd0);
    check("overlap served instr", {16'b0, bus.instr}, 32'h0046);
    mvalid[3] = 1'b1; mtag[3] = 7'd0; misses_model++;
    mvalid[4] = 1'b1; mtag[4] = 7'd0; misses_model++;

    // Reset in the middle of a fill; stale returns land while reset is held.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0806;
    #1;
    check("mid-fill miss stall", {31'b0, bus.stall}, 32'd1);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    check("mid-fill reset stall", {31'b0, bus.stall}, 32'd0);
    check("mid-fill reset mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("mid-fill reset miss_count", {16'b0, bus.miss_count}, 32'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_fetch(16'h0006, 1'b1, "post-reset refill");
    do_fetch(16'h0806, 1'b1, "post-reset aborted block");

    // Miss counter over three conflicting misses from a clean reset.
    do_reset(3);
    do_fetch(16'h0000, 1'b1, "stats a");
    do_fetch(16'h0200, 1'b1, "stats b");
    do_fetch(16'h0400, 1'b1, "stats c");
    idle_cycles(16'h7777, 2, "stats idle");
    check("stats miss_count", {16'b0, bus.miss_count}, STATS ? 32'd3 : 32'd0);

    // Random fetches over a small tag/index pool with varying memory latency.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      lat = int'($urandom_range(1, 6));
      if ($urandom_range(0, 4) == 0) begin
        idle_cycles(16'($urandom()), 1, $sformatf("rand%0d idle", n));
      end else begin
        a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
        do_fetch(a, model_miss(a), $sformatf("rand%0d %h", n, a));
      end
    end
    idle_cycles(16'h0000, 1, "final idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped instruction cache that answers the fetch stage's per-cycle instruction reads and refills missing blocks from multi-cycle main memory. Sits between the IF stage and the unified memory port. Hits return data combinationally in the request cycle. Misses hold `stall` high while an FSM streams one 8-word block from memory.

## Interface
Parameters:
- `MEM_WORDS`, default 8: words per cache block (fixed; offset field width derives from it).
- `NUM_SETS`, default 32: number of direct-mapped sets.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `fetch_req`  in  1  fetch is requesting an instruction this cycle.
- `fetch_addr`  in  16  byte address of the requested instruction (bit 0 ignored).
- `instr`  out  16  instruction word; valid when `fetch_req & ~stall`.
- `stall`  out  1  high while a request misses or a refill is in progress.
- `mem_rd`  out  1  read strobe to memory, one word per cycle.
- `mem_addr`  out  16  word-aligned byte address for `mem_rd`.
- `mem_data`  in  16  memory read data.
- `mem_data_valid`  in  1  `mem_data` carries the next returning word.
- `miss_count`  out  16  saturating miss counter (see Configuration).

## Operation
- Address split: offset `[3:1]` word, `[0]` ignored; index `[8:4]`; tag `[15:9]`.
- Storage: 32×8×16 data array; 32-entry tag array of 7 bits plus a valid bit.
- Hit: `fetch_req` is high, the FSM is in IDLE, the set is valid and the tags match.
  - `instr` = stored word.
  - `stall` = 0.
- Miss in IDLE:
  - `stall` = 1 combinationally in the same cycle.
  - Tag and index are latched at the edge.
  - FSM moves to FILL.
- FSM states:
  - IDLE: serve hits. A miss goes to FILL.
  - FILL: issue 8 reads, then collect returns. The 8th return goes to IDLE.
- FILL issue:
  - `mem_rd` = 1 for 8 consecutive cycles.
  - `mem_addr` = {latched tag, latched index, issue_cnt[2:0], 1'b0}.
  - issue_cnt counts 0..7; `mem_rd` drops once 8 reads are issued.
- FILL receive:
  - Each `mem_data_valid` cycle writes `mem_data` to word rx_cnt of the latched set; rx_cnt increments.
  - The controller counts valids and never assumes a fixed latency.
  - On the 8th valid: write the tag, set the valid bit, return to IDLE.
- Refill ordering:
  - The valid bit is cleared at the first FILL edge, so a partial block never hits.
  - The victim block is overwritten; there is no writeback because the cache is read-only.
- During FILL:
  - `stall` = 1 regardless of `fetch_req`.
  - `fetch_addr` changes are ignored; the fetch stage holds PC while stalled.
- `fetch_req` = 0:
  - In IDLE: no lookup, no miss, `stall` = 0, `instr` = 16'h0000.
  - An in-progress fill continues.
- `mem_data_valid` in IDLE: ignored.
- Reset mid-fill:
  - All valid bits cleared, FSM to IDLE, counters to 0.
  - Late returning words are ignored.

## Timing
- Reset values:
  - `instr` = 0, `stall` = 0, `mem_rd` = 0, `mem_addr` = 0, `miss_count` = 0.
  - All valid bits = 0; FSM = IDLE.
- Hit latency: 0 cycles (combinational).
- Miss timeline, miss detected in cycle t, memory latency 4 (read issued in cycle c returns in c+4):
  - Reads are issued t+1..t+8.
  - Data returns t+5..t+12.
  - The tag and valid bit are written at the end of t+12.
  - The hit is served in t+13.
  - `stall` is high for cycles t..t+12 (13 cycles).
- Simultaneous 8th `mem_data_valid` and new `fetch_addr`: the new address is looked up in the following IDLE cycle, not the same cycle.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `miss_count` increments by 1 at each IDLE→FILL transition.
  - It saturates at 16'hFFFF.
  - It resets to 0.
- `ICACHE_STATS_EN` undefined:
  - No counter logic; `miss_count` is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
Memory model: latency 4; the word at byte address A holds the value A.
- Cold miss: `fetch_req`=1, `fetch_addr`=0x0006 at cycle t -> `stall` high t..t+12; `mem_addr` 0x0000,0x0002..0x000E on t+1..t+8; `instr`=0x0006 with `stall`=0 at t+13.
- Hit after fill: then `fetch_addr`=0x000A -> `instr`=0x000A the same cycle, `stall`=0, `mem_rd`=0.
- Conflict eviction: after 0x0006 is filled, `fetch_addr`=0x0206 (same index 0, different tag) -> 13-cycle miss, `instr`=0x0206. Re-request 0x0006 -> misses again.
- Reset mid-fill: assert `rst`=0 at t+7 of a miss, release it, request 0x0006 -> `stall`=1 and a full 8-read refill restarts. Stale valids arriving during the reset window leave no valid set.
- Idle request: `fetch_req`=0 with an unmapped `fetch_addr` -> `stall`=0, `mem_rd`=0 throughout, `miss_count` unchanged.
- Stats: with `ICACHE_STATS_EN`, 3 misses (0x0000, 0x0200, 0x0400) -> `miss_count`=3. Without it -> `miss_count`=0.
